// File: rtl/sdram_write_buffer.sv
// rtl/sdram_write_buffer.sv - posted-write FIFO and read-ordering stage ahead of one SDRAM controller channel
module sdram_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 27
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_wr_req,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rd_done,
    output logic              fifo_full,
    output logic              buf_idle,
    output logic              overflow,
    output logic              ram_req,
    output logic              ram_rnw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic [3:0]        ram_be,
    input  logic              ram_ready,
    input  logic [31:0]       ram_dout
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [31:0]       mem_data [DEPTH];
    logic [3:0]        mem_be   [DEPTH];

    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     rd_ahead;
    logic              rd_pending;
    logic [ADDR_W-1:0] rd_addr;

    logic push, pop, issue_wr, issue_rd, rd_complete;

    // A full FIFO rejects the push even if the head pops this cycle.
    assign push      = cpu_wr_req && (count != DEPTH_C);
    assign fifo_full = (count == DEPTH_C);
    assign buf_idle  = (count == '0) && !rd_pending && (state == IDLE);

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        issue_wr    = 1'b0;
        issue_rd    = 1'b0;
        rd_complete = 1'b0;
        case (state)
            IDLE: begin
                if (rd_pending && (rd_ahead == '0)) begin
                    issue_rd = 1'b1;
                    state_n  = RD_WAIT;
                end else if (count != '0) begin
                    issue_wr = 1'b1;
                    state_n  = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (ram_ready) begin
                    pop     = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_WAIT: begin
                if (ram_ready) begin
                    rd_complete = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= cpu_addr;
            mem_data[wr_ptr] <= cpu_wdata;
            mem_be[wr_ptr]   <= cpu_be;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd_pending  <= 1'b0;
            rd_ahead    <= '0;
            rd_addr     <= '0;
            overflow    <= 1'b0;
            ram_req     <= 1'b0;
            ram_rnw     <= 1'b1;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_be      <= '0;
            cpu_rdata   <= '0;
            cpu_rd_done <= 1'b0;
        end else begin
            state <= state_n;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (cpu_wr_req && !push)
                overflow <= 1'b1;

            // rd_ahead counts the writes that must retire before the read may go.
            if (cpu_rd_req && !rd_pending) begin
                rd_pending <= 1'b1;
                rd_addr    <= cpu_addr;
                rd_ahead   <= count - CW'(pop) + CW'(push);
            end else if (rd_complete) begin
                rd_pending <= 1'b0;
            end else if (pop && rd_pending && (rd_ahead != '0)) begin
                rd_ahead <= rd_ahead - 1'b1;
            end

            ram_req <= issue_wr || issue_rd;
            if (issue_wr) begin
                ram_rnw  <= 1'b0;
                ram_addr <= mem_addr[rd_ptr];
                ram_din  <= mem_data[rd_ptr];
                ram_be   <= mem_be[rd_ptr];
            end else if (issue_rd) begin
                ram_rnw  <= 1'b1;
                ram_addr <= rd_addr;
            end

            cpu_rd_done <= rd_complete;
            if (rd_complete)
                cpu_rdata <= ram_dout;
        end
    end

endmodule
